// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI voice allocator.
//   - MIDI status-field constants (message-type bits [6:4] of the status byte)
//   - CC number for "All Notes Off"
//   - event classification enum and allocator FSM state enum
//   - classify(): maps a latched message triple to an event type
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF    = 4'd0;
  localparam logic [3:0] MIDI_NOTE_ON     = 4'd1;
  localparam logic [3:0] MIDI_CC          = 4'd3;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_ON,
    EV_OFF,
    EV_ALL_OFF
  } ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_APPLY
  } state_e;

  // Note-on with velocity 0 is the running-status idiom for note-off.
  function automatic ev_type_e classify(input logic [3:0] status,
                                        input logic [6:0] byte1,
                                        input logic [6:0] byte2);
    ev_type_e ev;
    ev = EV_NONE;
    case (status)
      MIDI_NOTE_ON:  ev = (byte2 != 7'd0) ? EV_ON : EV_OFF;
      MIDI_NOTE_OFF: ev = EV_OFF;
      MIDI_CC:       ev = (byte1 == CC_ALL_NOTES_OFF) ? EV_ALL_OFF : EV_NONE;
      default:       ev = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator.
// Takes decoded MIDI channel messages and maintains a table of NUM_VOICES
// voices: note-on allocates (match -> retrigger, else first free voice, else
// steal the oldest), note-off releases the matching voice, CC 123 gates off
// all voices. The table is walked one voice per cycle (SCAN), then updated
// in a single APPLY cycle.
//
// Ports:
//   clk_in, rst_in       clock, async active-low reset
//   status_in            message type (status byte bits [6:4], zero-extended)
//   data_byte1_in/2_in   note/controller number, velocity/value
//   valid_in             level; its rising edge is the event
//   voice_active_out     per-voice gate
//   voice_note_out       per-voice note number
//   voice_vel_out        per-voice velocity
//   voice_trig_out       one-cycle (re)trigger pulse per voice
//   busy_out             high during SCAN/APPLY
//   dropped_out          sticky: an event edge arrived while busy
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [3:0]                 status_in,
  input  logic [7:0]                 data_byte1_in,
  input  logic [7:0]                 data_byte2_in,
  input  logic                       valid_in,
  output logic [NUM_VOICES-1:0]      voice_active_out,
  output logic [NUM_VOICES-1:0][6:0] voice_note_out,
  output logic [NUM_VOICES-1:0][6:0] voice_vel_out,
  output logic [NUM_VOICES-1:0]      voice_trig_out,
  output logic                       busy_out,
  output logic                       dropped_out
);

  localparam int                IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

  state_e state_q, state_d;

  // Event capture
  logic     valid_prev_q;
  logic     rise;
  ev_type_e ev_class;
  ev_type_e ev_q;
  logic [6:0] ev_note_q, ev_vel_q;
  logic     dropped_q;

  // Voice table
  logic [NUM_VOICES-1:0]            active_q, active_d;
  logic [NUM_VOICES-1:0][6:0]       note_q, note_d;
  logic [NUM_VOICES-1:0][6:0]       vel_q, vel_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic [NUM_VOICES-1:0]            trig_q, trig_d;

  // Scan results
  logic [IDX_W-1:0] scan_idx_q;
  logic             match_found_q, free_found_q, old_found_q;
  logic [IDX_W-1:0] match_idx_q, free_idx_q, old_idx_q;
  logic             hit_match, hit_free, hit_old;
  logic [IDX_W-1:0] tgt;

  // Data bit 7 is always 0 in a legal MIDI data byte.
  logic unused_bits;
  assign unused_bits = data_byte1_in[7] ^ data_byte2_in[7];

  assign rise     = valid_in & ~valid_prev_q;
  assign ev_class = classify(status_in, data_byte1_in[6:0], data_byte2_in[6:0]);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Unrecognised messages are accepted but never leave IDLE.
        if (rise && ev_class != EV_NONE)
          state_d = (ev_class == EV_ALL_OFF) ? ST_APPLY : ST_SCAN;
      end
      ST_SCAN:  if (scan_idx_q == LAST_IDX) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_out = (state_q != ST_IDLE);
  end

  // ---------------- Event latch / drop flag ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_prev_q <= 1'b0;
      ev_q         <= EV_NONE;
      ev_note_q    <= '0;
      ev_vel_q     <= '0;
      dropped_q    <= 1'b0;
    end else begin
      valid_prev_q <= valid_in;
      if (rise && state_q == ST_IDLE) begin
        ev_q      <= ev_class;
        ev_note_q <= data_byte1_in[6:0];
        ev_vel_q  <= data_byte2_in[6:0];
      end
      if (rise && state_q != ST_IDLE) dropped_q <= 1'b1;
    end
  end

  // ---------------- Scan compare ----------------
  // Ages are frozen during SCAN, so the running oldest can be compared
  // against the table entry it points to instead of a separate copy.
  always_comb begin
    hit_match = active_q[scan_idx_q] && (note_q[scan_idx_q] == ev_note_q) && !match_found_q;
    hit_free  = !active_q[scan_idx_q] && !free_found_q;
    hit_old   = active_q[scan_idx_q] &&
                (!old_found_q || (age_q[scan_idx_q] > age_q[old_idx_q]));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
    end else if (state_q == ST_IDLE) begin
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
    end else if (state_q == ST_SCAN) begin
      scan_idx_q <= scan_idx_q + IDX_W'(1);
      if (hit_match) begin
        match_found_q <= 1'b1;
        match_idx_q   <= scan_idx_q;
      end
      if (hit_free) begin
        free_found_q <= 1'b1;
        free_idx_q   <= scan_idx_q;
      end
      if (hit_old) begin
        old_found_q <= 1'b1;
        old_idx_q   <= scan_idx_q;
      end
    end
  end

  // ---------------- Apply ----------------
  always_comb begin
    tgt = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);
  end

  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    vel_d    = vel_q;
    age_d    = age_q;
    trig_d   = '0;
    if (state_q == ST_APPLY) begin
      case (ev_q)
        EV_ALL_OFF: active_d = '0;
        EV_ON: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt) begin
              active_d[i] = 1'b1;
              note_d[i]   = ev_note_q;
              vel_d[i]    = ev_vel_q;
              age_d[i]    = '0;
              trig_d[i]   = 1'b1;
            end else if (active_q[i] && age_q[i] != AGE_MAX) begin
              age_d[i] = age_q[i] + AGE_W'(1);
            end
          end
        end
        EV_OFF: if (match_found_q) active_d[match_idx_q] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_q <= '0;
      note_q   <= '0;
      vel_q    <= '0;
      age_q    <= '0;
      trig_q   <= '0;
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      age_q    <= age_d;
      trig_q   <= trig_d;
    end
  end

  assign voice_active_out = active_q;
  assign voice_note_out   = note_q;
  assign voice_vel_out    = vel_q;
  assign voice_trig_out   = trig_q;
  assign dropped_out      = dropped_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
`timescale 1ns/1ps
module tb_midi_voice_allocator;

  localparam int N  = 4;
  localparam int AW = 4;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [3:0]        status_in = '0;
  logic [7:0]        data_byte1_in = '0;
  logic [7:0]        data_byte2_in = '0;
  logic              valid_in = 1'b0;
  logic [N-1:0]      voice_active_out;
  logic [N-1:0][6:0] voice_note_out;
  logic [N-1:0][6:0] voice_vel_out;
  logic [N-1:0]      voice_trig_out;
  logic              busy_out;
  logic              dropped_out;

  midi_voice_allocator #(.NUM_VOICES(N), .AGE_W(AW)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .status_in        (status_in),
    .data_byte1_in    (data_byte1_in),
    .data_byte2_in    (data_byte2_in),
    .valid_in         (valid_in),
    .voice_active_out (voice_active_out),
    .voice_note_out   (voice_note_out),
    .voice_vel_out    (voice_vel_out),
    .voice_trig_out   (voice_trig_out),
    .busy_out         (busy_out),
    .dropped_out      (dropped_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arrays, voice choice straight from the rules.
  bit m_act [N];
  int m_note[N];
  int m_vel [N];
  int m_age [N];
  bit m_drop;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    m_drop = 0;
  endtask

  // kind: 0 ignored, 1 on, 2 off, 3 all-off; tgt = voice triggered by an on.
  task automatic model_event(input int st, input int b1, input int b2,
                             output int kind, output int tgt);
    int m, f, o;
    kind = 0; tgt = -1;
    if (st == 1)      kind = (b2 != 0) ? 1 : 2;
    else if (st == 0) kind = 2;
    else if (st == 3) kind = (b1 == 123) ? 3 : 0;
    m = -1; f = -1; o = -1;
    for (int i = 0; i < N; i++) begin
      if (m_act[i] && m_note[i] == b1 && m < 0) m = i;
      if (!m_act[i] && f < 0) f = i;
      if (m_act[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
    end
    case (kind)
      1: begin
        tgt = (m >= 0) ? m : ((f >= 0) ? f : o);
        for (int i = 0; i < N; i++)
          if (i != tgt && m_act[i] && m_age[i] < (1 << AW) - 1) m_age[i]++;
        m_act[tgt] = 1; m_note[tgt] = b1; m_vel[tgt] = b2; m_age[tgt] = 0;
      end
      2: if (m >= 0) m_act[m] = 0;
      3: for (int i = 0; i < N; i++) m_act[i] = 0;
      default: ;
    endcase
  endtask

  task automatic check_table(input string tag);
    logic [N-1:0]      ea;
    logic [N-1:0][6:0] en, ev;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_act[i];
      en[i] = 7'(m_note[i]);
      ev[i] = 7'(m_vel[i]);
    end
    chk({tag, ".active"}, voice_active_out, ea);
    chk({tag, ".note"}, voice_note_out, en);
    chk({tag, ".vel"}, voice_vel_out, ev);
    chk({tag, ".dropped"}, dropped_out, m_drop);
  endtask

  // mode 0: single edge; 1: second edge during SCAN; 2: valid held 1000 extra cycles
  task automatic do_event(input string tag, input int st, input int b1, input int b2,
                          input int mode);
    int kind, tgt, trig_cnt, trig_at, extra;
    logic [N-1:0] trig_vec;
    logic exp_busy;
    @(negedge clk_in);
    status_in = 4'(st); data_byte1_in = 8'(b1); data_byte2_in = 8'(b2); valid_in = 1'b1;
    model_event(st, b1, b2, kind, tgt);
    trig_cnt = 0; trig_at = 0; trig_vec = '0;
    for (int n = 1; n <= N + 3; n++) begin
      @(negedge clk_in);
      if (kind == 1 || kind == 2) exp_busy = (n <= N + 1);
      else if (kind == 3)         exp_busy = (n == 1);
      else                        exp_busy = 1'b0;
      chk({tag, ".busy"}, busy_out, exp_busy);
      if (voice_trig_out != '0) begin
        trig_cnt++; trig_at = n; trig_vec = voice_trig_out;
      end
      if (mode != 2 && n == 1) valid_in = 1'b0;
      if (mode == 1 && n == 2) begin
        status_in = 4'd1; data_byte1_in = 8'($urandom_range(0, 127));
        data_byte2_in = 8'd99; valid_in = 1'b1; m_drop = 1;
      end
      if (mode == 1 && n == 3) valid_in = 1'b0;
    end
    if (kind == 1) begin
      chk({tag, ".trig_cnt"}, trig_cnt, 1);
      chk({tag, ".trig_lat"}, trig_at, N + 2);
      chk({tag, ".trig_vec"}, trig_vec, 64'(1) << tgt);
    end else begin
      chk({tag, ".no_trig"}, trig_cnt, 0);
    end
    if (mode == 2) begin
      extra = 0;
      repeat (1000) begin
        @(negedge clk_in);
        if (busy_out || voice_trig_out != '0) extra++;
      end
      chk({tag, ".hold_refire"}, extra, 0);
      valid_in = 1'b0;
      @(negedge clk_in);
    end
    check_table(tag);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0; valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st, b1, b2, r, busy_seen;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_table("reset");
    chk("reset.busy", busy_out, 1'b0);
    chk("reset.trig", voice_trig_out, '0);
    rst_in = 1'b1;

    // Reset mid-scan abandons the event.
    @(negedge clk_in);
    status_in = 4'd1; data_byte1_in = 8'd60; data_byte2_in = 8'd100; valid_in = 1'b1;
    @(negedge clk_in); valid_in = 1'b0;
    @(negedge clk_in); rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (busy_out || voice_trig_out != '0) busy_seen++;
    end
    chk("rst_scan.quiet", busy_seen, 0);
    check_table("rst_scan");

    // Allocate / release.
    do_event("on60", 1, 60, 100, 0);
    do_event("off60", 0, 60, 0, 0);
    chk("off60.note_kept", voice_note_out[0], 7'd60);
    do_event("on64v0", 1, 64, 0, 0);
    do_event("on60a", 1, 60, 100, 0);
    do_event("on60b", 1, 60, 50, 0);
    chk("retrig.vel", voice_vel_out[0], 7'd50);

    // Stealing.
    do_reset();
    do_event("fill0", 1, 60, 10, 0);
    do_event("fill1", 1, 62, 11, 0);
    do_event("fill2", 1, 64, 12, 0);
    do_event("fill3", 1, 65, 13, 0);
    do_event("steal0", 1, 67, 14, 0);
    chk("steal0.note", voice_note_out[0], 7'd67);
    do_event("steal1", 1, 69, 15, 0);
    chk("steal1.note", voice_note_out[1], 7'd69);

    // Level hold and drop.
    do_event("hold", 1, 70, 20, 2);
    do_event("drop", 1, 72, 30, 1);
    chk("drop.flag", dropped_out, 1'b1);

    // All-notes-off and ignored messages.
    do_reset();
    do_event("ao_a", 1, 40, 1, 0);
    do_event("ao_b", 1, 41, 2, 0);
    do_event("ao_c", 1, 42, 3, 0);
    do_event("alloff", 3, 123, 0, 0);
    do_event("cc7", 3, 7, 64, 0);
    do_event("st6", 6, 50, 50, 0);

    // Random traffic, narrow note range to exercise match/steal paths.
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 99);
      b1 = $urandom_range(60, 67);
      b2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
      if (r < 55)      st = 1;
      else if (r < 85) st = 0;
      else if (r < 90) begin st = 3; b1 = 123; end
      else if (r < 95) begin st = 3; b1 = $urandom_range(0, 122); end
      else             st = $urandom_range(4, 7);
      do_event("rand", st, b1, b2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
